fpga_tx_controller: RTL

Sequencing controller for the FPGA-to-FPGA serial link transmitter. It accepts a byte through a valid/ready handshake and drives the load and shift strobes of the link shift register. It also produces the framed serial line: one start bit, DATA_BITS data bits MSB-first, and one stop bit, each held for CLKS_PER_BIT clocks. It sits between the user-side byte source and the shift register, which holds the byte and presents its outgoing bit.

---
 rtl/fpga_link_pkg.sv | 19 +
 rtl/fpga_tx_controller_if.sv | 35 +++
 rtl/fpga_baud_counter.sv | 29 ++
 rtl/fpga_tx_controller.sv | 93 +++++++++
 4 files changed

// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link controllers.
package fpga_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } link_state_e;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/fpga_tx_controller_if.sv
// Handshake and shift-register strobe bundle between the tx controller and its surroundings.
interface fpga_tx_controller_if;

    logic tx_valid;
    logic tx_ready;
    logic sr_load;
    logic sr_shift;
    logic sr_bit;
    logic tx_line;
    logic busy;
    logic tx_done;

    modport master (
        input  tx_valid,
        input  sr_bit,
        output tx_ready,
        output sr_load,
        output sr_shift,
        output tx_line,
        output busy,
        output tx_done
    );

    modport slave (
        output tx_valid,
        output sr_bit,
        input  tx_ready,
        input  sr_load,
        input  sr_shift,
        input  tx_line,
        input  busy,
        input  tx_done
    );

endinterface

// File: rtl/fpga_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last count.
module fpga_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] TC = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = i_enable && (r_count == TC);

endmodule

// File: rtl/fpga_tx_controller.sv
// Transmit sequencer: accepts a byte, strobes the shift register and frames start/data/stop on the line.
module fpga_tx_controller
    import fpga_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    fpga_tx_controller_if.master  bus
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    link_state_e   r_state;
    logic [BW-1:0] r_bit_cnt;
    logic          w_timing;
    logic          w_tc;
    logic          w_baud_clr;

    // Counter only runs in the timed states; clearing at terminal count restarts each bit period.
    assign w_timing   = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
    assign w_baud_clr = !w_timing || w_tc;

    fpga_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_baud_clr),
        .i_enable (w_timing),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (bus.tx_valid) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_START;
                end
                ST_START: begin
                    r_bit_cnt <= '0;
                    if (w_tc) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_tc) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    r_bit_cnt <= '0;
                    if (w_tc) r_state <= ST_IDLE;
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from registered state only, so reset forces them low immediately.
    assign bus.tx_ready = (r_state == ST_IDLE);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.sr_load  = (r_state == ST_LOAD);
    assign bus.sr_shift = (r_state == ST_DATA) && w_tc;
    assign bus.tx_done  = (r_state == ST_STOP) && w_tc;

    always_comb begin
        bus.tx_line = LINE_IDLE;
        case (r_state)
            ST_START: bus.tx_line = LINE_START;
            ST_DATA:  bus.tx_line = bus.sr_bit;
            ST_STOP:  bus.tx_line = LINE_STOP;
            default:  bus.tx_line = LINE_IDLE;
        endcase
    end

endmodule
